// File: rtl/countdown_timer_pkg.sv
// ---------------------------------------------------------------------------
// countdown_timer_pkg
//
// Shared definitions for the countdown timer slice:
//   - FSM state encoding, kept as plain 2-bit constants so legacy blocks that
//     compare against raw codes keep working.
//   - Helper used to size the prescaler counter register.
// ---------------------------------------------------------------------------
package countdown_timer_pkg;

    // FSM state codes. 2'b11 is unused; the FSM sends it back to IDLE.
    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_RUN    = 2'b01;
    localparam logic [1:0] ST_PAUSED = 2'b10;

    // Smallest legal prescale ratio. Values below this act like a ratio of 1.
    localparam int MIN_PRESCALE = 1;

    // Width of the prescaler counter: enough bits to hold PRESCALE-1, and never
    // less than one bit, so that a ratio of 1 still gives a valid register.
    function automatic int prescale_width(input int prescale);
        int w;
        if (prescale <= 2) begin
            w = 1;
        end else begin
            w = $clog2(prescale);
        end
        return w;
    endfunction

endpackage : countdown_timer_pkg

// File: rtl/tick_prescaler.sv
// ---------------------------------------------------------------------------
// tick_prescaler
//
// Modulo-PRESCALE cycle counter. Each cycle with 'enable' high advances the
// count. The cycle that would take the count past PRESCALE-1 raises 'tick'
// and returns the count to zero. 'clear' forces the count back to zero and
// takes priority over 'enable'. The count holds when neither is asserted,
// which lets the parent freeze it during a pause.
//
// Ports:
//   CLK     in   clock, rising-edge active
//   RST_N   in   asynchronous active-low reset (count -> 0)
//   clear   in   synchronous clear of the count
//   enable  in   advance the count this cycle
//   tick    out  combinational, high on the enabled cycle that wraps the count
// ---------------------------------------------------------------------------
module tick_prescaler
    import countdown_timer_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int PW = prescale_width(PRESCALE);

    // Terminal count. With PRESCALE=1 this is zero, so every enabled cycle
    // becomes a tick and the counter never leaves zero.
    localparam logic [PW-1:0] LAST =
        (PRESCALE > MIN_PRESCALE) ? PW'(PRESCALE - 1) : '0;

    logic [PW-1:0] count;

    // The tick is decoded combinationally. This lets the parent act on the
    // wrapping cycle itself and adds no extra cycle of latency to a decrement.
    assign tick = enable && (count == LAST);

    // Counter register. Clear wins over enable. A tick wraps the count to
    // zero instead of incrementing it.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            if (count == LAST) begin
                count <= '0;
            end else begin
                count <= count + PW'(1);
            end
        end
    end

endmodule : tick_prescaler

// File: rtl/countdown_timer.sv
// ---------------------------------------------------------------------------
// countdown_timer
//
// Loadable, pausable down-counter used as a delay and timeout primitive.
// LOAD copies D into Q. START counts Q down to zero, one step every PRESCALE
// un-paused run cycles. Reaching zero raises DONE for one cycle.
//
// Ports:
//   CLK    in   clock, rising-edge active
//   RST_N  in   asynchronous active-low reset
//   LOAD   in   load D into Q and abort any run in progress
//   D      in   value to load (WIDTH bits)
//   START  in   begin counting down from Q (ignored unless idle)
//   PAUSE  in   freeze counting while high
//   Q      out  current count (registered)
//   BUSY   out  high while running or paused
//   DONE   out  one-cycle completion pulse (registered)
//   ZERO   out  Q == 0, decoded from the Q register
// ---------------------------------------------------------------------------
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] D,
    input  logic             START,
    input  logic             PAUSE,
    output logic [WIDTH-1:0] Q,
    output logic             BUSY,
    output logic             DONE,
    output logic             ZERO
);

    logic [1:0] state;
    logic       start_accept;
    logic       state_illegal;
    logic       pre_clear;
    logic       pre_enable;
    logic       tick;

    // A START only begins a run from IDLE with something left to count.
    // LOAD in the same cycle overrides it.
    assign start_accept = (state == ST_IDLE) && START && !LOAD && (Q != '0);

    assign state_illegal = (state != ST_IDLE) && (state != ST_RUN) &&
                           (state != ST_PAUSED);

    // The prescaler restarts from zero on every load and on every new run,
    // so the first decrement always lands exactly PRESCALE advance cycles
    // after START. It also restarts when the FSM recovers from a corrupted
    // state code. It is left alone while paused, so a pause resumes the
    // partial interval rather than restarting it.
    assign pre_clear = LOAD || start_accept || state_illegal;

    // Only un-paused cycles in RUN advance the prescaler. The cycle that
    // leaves PAUSED sits in PAUSED state, so it does not advance either.
    assign pre_enable = (state == ST_RUN) && !PAUSE && !LOAD;

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .clear  (pre_clear),
        .enable (pre_enable),
        .tick   (tick)
    );

    // Main FSM together with the Q and DONE registers. Priority is reset,
    // then LOAD, then the per-state behaviour. DONE defaults low every cycle,
    // so it can only ever be a single-cycle pulse.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= ST_IDLE;
            Q     <= '0;
            DONE  <= 1'b0;
        end else begin
            DONE <= 1'b0;
            if (LOAD) begin
                Q     <= D;
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (START) begin
                            if (Q != '0) begin
                                state <= ST_RUN;
                            end else begin
                                // Nothing to count: complete at once.
                                DONE <= 1'b1;
                            end
                        end
                    end

                    ST_RUN: begin
                        if (PAUSE) begin
                            state <= ST_PAUSED;
                        end else if (tick) begin
                            if (Q <= WIDTH'(1)) begin
                                // Last step, or a zero count that should not
                                // be here at all. Finish without wrapping.
                                Q     <= '0;
                                state <= ST_IDLE;
                                DONE  <= 1'b1;
                            end else begin
                                Q <= Q - WIDTH'(1);
                            end
                        end
                    end

                    ST_PAUSED: begin
                        if (!PAUSE) begin
                            state <= ST_RUN;
                        end
                    end

                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Output decode, taken straight from the registers.
    assign BUSY = (state != ST_IDLE);
    assign ZERO = (Q == '0);

endmodule : countdown_timer

// File: tb/tb_countdown_timer.sv
// ---------------------------------------------------------------------------
// tb_countdown_timer
//
// Two timer instances, with PRESCALE=1 and PRESCALE=3, share one stimulus
// stream. After every edge, both are compared against a reference model.
// The model tracks how many advance cycles have elapsed since START and
// derives the expected count arithmetically from that total.
// ---------------------------------------------------------------------------
module tb_countdown_timer;

    localparam int WIDTH = 4;

    logic             CLK = 1'b0;
    logic             RST_N;
    logic             LOAD;
    logic [WIDTH-1:0] D;
    logic             START;
    logic             PAUSE;

    logic [WIDTH-1:0] q1, q3;
    logic             busy1, busy3, done1, done3, zero1, zero3;

    int checks = 0;
    int errors = 0;

    // Reference model state, index 0 = PRESCALE 1, index 1 = PRESCALE 3.
    int presc [2] = '{1, 3};
    int mQ    [2];
    int mBusy [2];
    int mPause[2];
    int mStart[2];
    int mAdv  [2];
    int mDone [2];

    always #5 CLK = ~CLK;

    countdown_timer #(.WIDTH(WIDTH), .PRESCALE(1)) dut1 (
        .CLK(CLK), .RST_N(RST_N), .LOAD(LOAD), .D(D), .START(START),
        .PAUSE(PAUSE), .Q(q1), .BUSY(busy1), .DONE(done1), .ZERO(zero1)
    );

    countdown_timer #(.WIDTH(WIDTH), .PRESCALE(3)) dut3 (
        .CLK(CLK), .RST_N(RST_N), .LOAD(LOAD), .D(D), .START(START),
        .PAUSE(PAUSE), .Q(q3), .BUSY(busy3), .DONE(done3), .ZERO(zero3)
    );

    task automatic expectVal(input string tag, input logic [31:0] got,
                             input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("[TB] FAIL %s got %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic void modelReset();
        for (int i = 0; i < 2; i++) begin
            mQ[i] = 0; mBusy[i] = 0; mPause[i] = 0;
            mStart[i] = 0; mAdv[i] = 0; mDone[i] = 0;
        end
    endfunction

    // One clock edge of the behavioural reference, using the sampled inputs.
    function automatic void modelEdge(input logic l, input int d,
                                      input logic s, input logic p);
        for (int i = 0; i < 2; i++) begin
            mDone[i] = 0;
            if (l) begin
                mQ[i] = d; mBusy[i] = 0; mPause[i] = 0;
            end else if (mBusy[i] == 0) begin
                if (s) begin
                    if (mQ[i] != 0) begin
                        mBusy[i] = 1; mStart[i] = mQ[i]; mAdv[i] = 0;
                    end else begin
                        mDone[i] = 1;
                    end
                end
            end else if (mPause[i] != 0) begin
                if (!p) mPause[i] = 0;
            end else if (p) begin
                mPause[i] = 1;
            end else begin
                mAdv[i]++;
                mQ[i] = mStart[i] - mAdv[i] / presc[i];
                if (mAdv[i] == mStart[i] * presc[i]) begin
                    mBusy[i] = 0;
                    mDone[i] = 1;
                end
            end
        end
    endfunction

    task automatic checkOutput(input string tag);
        expectVal({tag, ".p1.Q"},    32'(q1),    32'(mQ[0]));
        expectVal({tag, ".p1.BUSY"}, 32'(busy1), 32'(mBusy[0]));
        expectVal({tag, ".p1.DONE"}, 32'(done1), 32'(mDone[0]));
        expectVal({tag, ".p1.ZERO"}, 32'(zero1), 32'(mQ[0] == 0));
        expectVal({tag, ".p3.Q"},    32'(q3),    32'(mQ[1]));
        expectVal({tag, ".p3.BUSY"}, 32'(busy3), 32'(mBusy[1]));
        expectVal({tag, ".p3.DONE"}, 32'(done3), 32'(mDone[1]));
        expectVal({tag, ".p3.ZERO"}, 32'(zero3), 32'(mQ[1] == 0));
    endtask

    // Drive inputs away from the edge, clock once, update the model, then
    // sample the outputs 1ns after the edge.
    task automatic applyStimulus(input logic l, input int d, input logic s,
                                 input logic p, input string tag);
        LOAD = l; D = WIDTH'(d); START = s; PAUSE = p;
        @(posedge CLK);
        modelEdge(l, d, s, p);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        int guard;
        int doneCount;
        int stepsToDone;

        RST_N = 1'b0; LOAD = 1'b0; D = '0; START = 1'b0; PAUSE = 1'b0;
        modelReset();

        // Reset values.
        #12;
        checkOutput("reset");
        RST_N = 1'b1;
        applyStimulus(0, 0, 0, 0, "postReset");

        // Asynchronous reset in the middle of a run.
        applyStimulus(1, 9, 0, 0, "rst.load");
        applyStimulus(0, 0, 1, 0, "rst.start");
        guard = 0;
        while (mQ[0] != 6 && guard < 20) begin
            applyStimulus(0, 0, 0, 0, "rst.run");
            guard++;
        end
        expectVal("rst.reachQ6", 32'(guard < 20), 32'd1);
        #1 RST_N = 1'b0;
        #1;
        expectVal("rst.async.Q",    32'(q1),    32'd0);
        expectVal("rst.async.BUSY", 32'(busy1), 32'd0);
        expectVal("rst.async.DONE", 32'(done1), 32'd0);
        expectVal("rst.async.ZERO", 32'(zero1), 32'd1);
        modelReset();
        @(posedge CLK);
        #1;
        checkOutput("rst.hold");
        RST_N = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, "rst.after");

        // Basic count, then let the prescaled instance finish too.
        applyStimulus(1, 5, 0, 0, "basic.load");
        applyStimulus(0, 0, 1, 0, "basic.start");
        for (int i = 1; i <= 15; i++) begin
            applyStimulus(0, 0, 0, 0, "basic.run");
            if (i <= 5) expectVal("basic.seqQ", 32'(q1), 32'(5 - i));
            if (i == 5) begin
                expectVal("basic.done", 32'(done1), 32'd1);
                expectVal("basic.busy", 32'(busy1), 32'd0);
            end
        end

        // Prescaled count: load 2, start at edge k.
        applyStimulus(1, 2, 0, 0, "presc.load");
        applyStimulus(0, 0, 1, 0, "presc.start");
        for (int i = 1; i <= 7; i++) begin
            applyStimulus(0, 0, 0, 0, "presc.run");
            if (i == 3) expectVal("presc.q1", 32'(q3), 32'd1);
            if (i == 6) begin
                expectVal("presc.q0",   32'(q3),    32'd0);
                expectVal("presc.done", 32'(done3), 32'd1);
            end
        end

        // Pause for 3 cycles after the first decrement.
        applyStimulus(1, 4, 0, 0, "pause.load");
        applyStimulus(0, 0, 1, 0, "pause.start");
        applyStimulus(0, 0, 0, 0, "pause.first");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 1, "pause.hold");
            expectVal("pause.holdQ", 32'(q1), 32'd3);
        end
        stepsToDone = 4;
        guard = 0;
        while (!done1 && guard < 20) begin
            applyStimulus(0, 0, 0, 0, "pause.resume");
            stepsToDone++;
            guard++;
        end
        expectVal("pause.latency", 32'(stepsToDone), 32'd8);
        for (int i = 0; i < 12; i++) applyStimulus(0, 0, 0, 0, "pause.drain");

        // Zero start.
        applyStimulus(1, 0, 0, 0, "zero.load");
        applyStimulus(0, 0, 1, 0, "zero.start");
        expectVal("zero.done", 32'(done1), 32'd1);
        expectVal("zero.busy", 32'(busy1), 32'd0);
        applyStimulus(0, 0, 0, 0, "zero.after");
        expectVal("zero.doneLow", 32'(done1), 32'd0);

        // Abort with LOAD+START, then count down from the maximum value.
        applyStimulus(1, 9, 0, 0, "abort.load");
        applyStimulus(0, 0, 1, 0, "abort.start");
        applyStimulus(0, 0, 0, 0, "abort.run");
        applyStimulus(0, 0, 0, 0, "abort.run");
        applyStimulus(1, 15, 1, 0, "abort.loadStart");
        expectVal("abort.Q",    32'(q1),    32'd15);
        expectVal("abort.BUSY", 32'(busy1), 32'd0);
        expectVal("abort.DONE", 32'(done1), 32'd0);
        applyStimulus(0, 0, 1, 0, "max.start");
        doneCount = 0;
        for (int i = 1; i <= 15; i++) begin
            applyStimulus(0, 0, 0, 0, "max.run");
            expectVal("max.seqQ", 32'(q1), 32'(15 - i));
            if (done1) doneCount++;
        end
        expectVal("max.doneCount", 32'(doneCount), 32'd1);
        // Back-to-back: START in the DONE cycle is accepted (Q is 0 now).
        applyStimulus(0, 0, 1, 0, "max.restart");
        expectVal("max.restartDone", 32'(done1), 32'd1);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 11) == 0),
                          int'($urandom_range(0, 15)),
                          ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 4) == 0), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_countdown_timer
